uart_cmd_parser: RTL and testbench

//  Downstream of uart_rx in the FPGA_to_NANO link. Consumes received bytes and parity flags.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/byte_timeout_timer.sv | 30 +++
 rtl/uart_cmd_parser.sv | 151 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command link: parser states, framing
// constants, command codes and the running checksum step.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } parser_state_t;

  localparam logic [7:0] DEFAULT_START_BYTE = 8'hAA;

  localparam logic [7:0] CMD_STOP       = 8'h00;
  localparam logic [7:0] CMD_GOTO_TABLE = 8'h01;
  localparam logic [7:0] CMD_SPEED      = 8'h02;

  function automatic logic [7:0] chk_xor(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte idle timer: counts clocks while enabled and flags expiry
// after TIMEOUT_CLKS-1 clocks without a restart.
module byte_timeout_timer #(
  parameter int TIMEOUT_CLKS = 4340
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] count_reg;

  assign expired = enable && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (!enable || restart) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames received UART bytes into START/CMD/LEN/PAYLOAD/CHK packets and
// hands checksum-valid commands downstream over valid/ready.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] START_BYTE   = DEFAULT_START_BYTE,
  parameter int         MAX_PAYLOAD  = 4,
  parameter int         TIMEOUT_CLKS = 4340
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     parity_err,
  output logic [7:0]               cmd_out,
  output logic [3:0]               len_out,
  output logic [8*MAX_PAYLOAD-1:0] payload_out,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               err_count,
  output logic                     overrun
);

  parser_state_t state_reg, state_next;
  logic [7:0] cmd_reg, acc_reg, err_reg;
  logic [3:0] len_reg, idx_reg;
  logic       overrun_reg;
  logic       err_pulse, overrun_set, start_frame, latch_cmd, latch_len, store_byte, acc_update;
  logic       in_frame, timer_expired;

  assign in_frame = state_reg inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK};

  byte_timeout_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (byte_valid),
    .enable  (in_frame),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    err_pulse   = 1'b0;
    overrun_set = 1'b0;
    start_frame = 1'b0;
    latch_cmd   = 1'b0;
    latch_len   = 1'b0;
    store_byte  = 1'b0;
    acc_update  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (byte_valid && !parity_err && byte_in == START_BYTE) begin
          state_next  = ST_CMD;
          start_frame = 1'b1;
        end
      end
      ST_HOLD: begin
        // Any byte here is lost, including one arriving in the handshake cycle.
        if (byte_valid) overrun_set = 1'b1;
        if (cmd_ready)  state_next  = ST_IDLE;
      end
      default: begin
        if (byte_valid && parity_err) begin
          err_pulse  = 1'b1;
          state_next = ST_IDLE;
        end else if (byte_valid) begin
          case (state_reg)
            ST_CMD: begin
              latch_cmd  = 1'b1;
              acc_update = 1'b1;
              state_next = ST_LEN;
            end
            ST_LEN: begin
              if (byte_in > 8'(MAX_PAYLOAD)) begin
                err_pulse  = 1'b1;
                state_next = ST_IDLE;
              end else begin
                latch_len  = 1'b1;
                acc_update = 1'b1;
                state_next = (byte_in == 8'd0) ? ST_CHECK : ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              store_byte = 1'b1;
              acc_update = 1'b1;
              if (idx_reg == len_reg - 4'd1) state_next = ST_CHECK;
            end
            ST_CHECK: begin
              if (byte_in == acc_reg) begin
                state_next = ST_HOLD;
              end else begin
                err_pulse  = 1'b1;
                state_next = ST_IDLE;
              end
            end
            default: state_next = ST_IDLE;
          endcase
        end else if (timer_expired) begin
          err_pulse  = 1'b1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_reg     <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      acc_reg     <= '0;
      err_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (start_frame)     acc_reg <= '0;
      else if (acc_update) acc_reg <= chk_xor(acc_reg, byte_in);
      if (latch_cmd) cmd_reg <= byte_in;
      if (latch_len) begin
        len_reg <= byte_in[3:0];
        idx_reg <= '0;
      end else if (store_byte) begin
        idx_reg <= idx_reg + 4'd1;
      end
      if (err_pulse && err_reg != 8'hFF) err_reg <= err_reg + 8'd1;
      if (overrun_set) overrun_reg <= 1'b1;
    end
  end

  // Every payload byte is cleared at frame start so unused slots read zero.
  for (genvar gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_payload
    logic [7:0] byte_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                  byte_reg <= '0;
      else if (start_frame)                      byte_reg <= '0;
      else if (store_byte && idx_reg == 4'(gi))  byte_reg <= byte_in;
    end
    assign payload_out[8*gi +: 8] = byte_reg;
  end

  assign cmd_out   = cmd_reg;
  assign len_out   = len_reg;
  assign cmd_valid = (state_reg == ST_HOLD);
  assign err_count = err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized frame checks for uart_cmd_parser against a
// frame-level reference model.
module tb_uart_cmd_parser;
  import uart_pkg::*;

  localparam int MAXP    = 4;
  localparam int TIMEOUT = 4340;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            parity_err;
  logic [7:0]      cmd_out;
  logic [3:0]      len_out;
  logic [8*MAXP-1:0] payload_out;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      err_count;
  logic            overrun;

  int checks = 0;
  int errors = 0;
  int err_model = 0;

  uart_cmd_parser #(
    .START_BYTE   (8'hAA),
    .MAX_PAYLOAD  (MAXP),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .parity_err  (parity_err),
    .cmd_out     (cmd_out),
    .len_out     (len_out),
    .payload_out (payload_out),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .err_count   (err_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par);
    byte_in    = b;
    byte_valid = 1'b1;
    parity_err = par;
    tick();
    byte_valid = 1'b0;
    parity_err = 1'b0;
    byte_in    = 8'h00;
  endtask

  // Sends q; the byte at par_pos (if >= 0) carries a parity error and ends the sequence.
  task automatic send_seq(input logic [7:0] q[$], input int par_pos, input int max_gap);
    for (int i = 0; i < q.size(); i++) begin
      if (par_pos >= 0 && i > par_pos) break;
      send_byte(q[i], (i == par_pos));
      if (i != q.size() - 1 && i != par_pos)
        repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  // Frame-level model: q = {START, CMD, LEN, payload..., CHK}.
  function automatic bit frame_ok(input logic [7:0] q[$]);
    logic [7:0] x;
    if (q.size() < 4 || q[2] > 8'(MAXP) || q.size() != int'(q[2]) + 4) return 1'b0;
    x = 8'h00;
    for (int i = 1; i < q.size() - 1; i++) x = x ^ q[i];
    return x == q[q.size() - 1];
  endfunction

  function automatic logic [31:0] exp_payload(input logic [7:0] q[$]);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < int'(q[2]); i++) p[8*i +: 8] = q[3 + i];
    return p;
  endfunction

  function automatic logic [7:0] xor_sum(input logic [7:0] q[$]);
    logic [7:0] x;
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  task automatic bump_err();
    if (err_model < 255) err_model++;
  endtask

  // Consumer takes the held command after `hold` extra cycles.
  task automatic accept_after(input int hold, input string tag);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, "_held_valid"}, 32'(cmd_valid), 32'd1);
    end
    cmd_ready = 1'b1;
    tick();
    chk({tag, "_valid_clear"}, 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] pl[$];
    logic [7:0] c, l;
    int kind, ppos, hold;

    rst = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; parity_err = 1'b0; cmd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid",   32'(cmd_valid),   32'd0);
    chk("rst_err",     32'(err_count),   32'd0);
    chk("rst_overrun", 32'(overrun),     32'd0);
    chk("rst_cmd",     32'(cmd_out),     32'd0);
    chk("rst_len",     32'(len_out),     32'd0);
    chk("rst_payload", payload_out,      32'd0);
    rst = 1'b1;
    tick();

    // Good frame, consumer always ready: valid for exactly one cycle.
    cmd_ready = 1'b1;
    q = {8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_seq(q, -1, 0);
    chk("good_valid",   32'(cmd_valid), 32'd1);
    chk("good_cmd",     32'(cmd_out),   32'(CMD_GOTO_TABLE));
    chk("good_len",     32'(len_out),   32'd2);
    chk("good_payload", payload_out,    32'h0000_2010);
    chk("good_err",     32'(err_count), 32'd0);
    tick();
    chk("good_one_cycle", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;
    $display("txn good_frame cmd=%0h len=%0d", cmd_out, len_out);

    // Zero-length frame held for 20 clocks.
    q = {8'hAA, 8'h05, 8'h00, 8'h05};
    send_seq(q, -1, 0);
    for (int k = 0; k < 20; k++) begin
      chk("zl_valid", 32'(cmd_valid), 32'd1);
      chk("zl_cmd",   32'(cmd_out),   32'h05);
      chk("zl_len",   32'(len_out),   32'd0);
      chk("zl_pay",   payload_out,    32'd0);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("zl_clear", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;
    $display("txn zero_length_frame");

    // Bad checksum, then a good frame.
    q = {8'hAA, 8'h01, 8'h01, 8'h10, 8'h00};
    send_seq(q, -1, 0); bump_err();
    chk("badchk_valid", 32'(cmd_valid), 32'd0);
    chk("badchk_err",   32'(err_count), 32'(err_model));
    q = {8'hAA, 8'h02, 8'h00, 8'h02};
    send_seq(q, -1, 0);
    chk("after_bad_valid", 32'(cmd_valid), 32'd1);
    chk("after_bad_cmd",   32'(cmd_out),   32'(CMD_SPEED));
    accept_after(0, "after_bad");
    $display("txn bad_checksum_then_good err=%0d", err_count);

    // LEN above maximum, then parity error on the CMD byte.
    q = {8'hAA, 8'h03, 8'h05};
    send_seq(q, -1, 0); bump_err();
    chk("biglen_err", 32'(err_count), 32'(err_model));
    q = {8'hAA, 8'h01};
    send_seq(q, 1, 0); bump_err();
    chk("parity_err", 32'(err_count), 32'(err_model));
    $display("txn len_and_parity_errors err=%0d", err_count);

    // Noise in IDLE is ignored; then a stalled frame times out.
    q = {CMD_STOP, 8'hFF};
    send_seq(q, -1, 1);
    chk("noise_err", 32'(err_count), 32'(err_model));
    q = {8'hAA, 8'h01};
    send_seq(q, -1, 0);
    repeat (TIMEOUT - 1) tick();
    chk("timeout_not_yet", 32'(err_count), 32'(err_model));
    tick(); bump_err();
    chk("timeout_err", 32'(err_count), 32'(err_model));
    q = {8'hAA, 8'h01, 8'h01, 8'h44, 8'h44};
    send_seq(q, -1, 0);
    chk("post_timeout_valid", 32'(cmd_valid), 32'd1);
    chk("post_timeout_pay",   payload_out,    32'h0000_0044);
    accept_after(0, "post_timeout");
    $display("txn timeout err=%0d", err_count);

    // Extra byte during HOLD.
    q = {8'hAA, 8'h02, 8'h01, 8'h07, 8'h04};
    send_seq(q, -1, 0);
    chk("ovr_before", 32'(overrun), 32'd0);
    send_byte(8'h55, 1'b0);
    chk("ovr_set",   32'(overrun),   32'd1);
    chk("ovr_valid", 32'(cmd_valid), 32'd1);
    chk("ovr_cmd",   32'(cmd_out),   32'h02);
    chk("ovr_len",   32'(len_out),   32'd1);
    chk("ovr_pay",   payload_out,    32'h0000_0007);
    accept_after(1, "ovr");
    $display("txn overrun overrun=%0b", overrun);

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      c = 8'($urandom);
      pl = {};
      if (kind == 2) begin
        q = {8'hAA, c, 8'($urandom_range(MAXP + 1, 255))};
      end else begin
        l = 8'($urandom_range(0, MAXP));
        for (int i = 0; i < int'(l); i++) pl.push_back(8'($urandom));
        q = {8'hAA, c, l};
        foreach (pl[i]) q.push_back(pl[i]);
        q.push_back(xor_sum({c, l}) ^ xor_sum(pl) ^ ((kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00));
      end
      ppos = (kind == 3) ? int'($urandom_range(1, q.size() - 1)) : -1;
      send_seq(q, ppos, 3);
      if (ppos < 0 && frame_ok(q)) begin
        chk("rnd_valid", 32'(cmd_valid), 32'd1);
        chk("rnd_cmd",   32'(cmd_out),   32'(q[1]));
        chk("rnd_len",   32'(len_out),   32'(q[2]));
        chk("rnd_pay",   payload_out,    exp_payload(q));
        chk("rnd_err",   32'(err_count), 32'(err_model));
        hold = $urandom_range(0, 3);
        accept_after(hold, "rnd");
      end else begin
        bump_err();
        chk("rnd_drop_valid", 32'(cmd_valid), 32'd0);
        chk("rnd_drop_err",   32'(err_count), 32'(err_model));
      end
      $display("txn random %0d kind=%0d bytes=%0d err=%0d", n, kind, q.size(), err_count);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Saturation of the error counter.
    for (int n = 0; n < 300; n++) begin
      q = {8'hAA, 8'($urandom)};
      send_seq(q, 1, 0);
      bump_err();
    end
    chk("sat_model", 32'(err_model), 32'd255);
    chk("sat_err",   32'(err_count), 32'hFF);
    $display("txn saturation err=%0h", err_count);

    // Asynchronous reset in the middle of a payload.
    q = {8'hAA, 8'h01, 8'h03, 8'h11};
    send_seq(q, -1, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid",   32'(cmd_valid), 32'd0);
    chk("arst_err",     32'(err_count), 32'd0);
    chk("arst_overrun", 32'(overrun),   32'd0);
    chk("arst_cmd",     32'(cmd_out),   32'd0);
    chk("arst_len",     32'(len_out),   32'd0);
    chk("arst_pay",     payload_out,    32'd0);
    tick();
    rst = 1'b1;
    tick();
    err_model = 0;
    q = {8'hAA, 8'h02, 8'h02, 8'h12, 8'h34};
    q.push_back(xor_sum({8'h02, 8'h02, 8'h12, 8'h34}));
    send_seq(q, -1, 0);
    chk("post_rst_valid", 32'(cmd_valid), 32'd1);
    chk("post_rst_pay",   payload_out,    32'h0000_3412);
    chk("post_rst_err",   32'(err_count), 32'(err_model));
    accept_after(0, "post_rst");
    $display("txn reset_mid_payload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
